imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader.sv | 147 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: length-prefixed byte stream -> sequential big-endian IMEM word writes, then releases the core.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte before cpu_run is granted.
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
`ifdef BOOT_CHECKSUM_EN
    CHK    = 3'd5,
`endif
    ERR    = 3'd4
  } state_t;

  // State entered once the payload (possibly empty) has been fully received.
`ifdef BOOT_CHECKSUM_EN
  localparam state_t PAY_END = CHK;
`else
  localparam state_t PAY_END = DONE;
`endif

  state_t            state_q, state_d;
  logic [7:0]        hdr_hi_q, hdr_hi_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       asm_q, asm_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  logic              in_ready_d, we_d, run_d, busy_d, error_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic [ADDR_W:0]   wl_d;
  logic              accept;

  assign accept = in_valid && in_ready;

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_d  = state_q;
    hdr_hi_d = hdr_hi_q;
    len_d    = len_q;
    bcnt_d   = bcnt_q;
    asm_d    = asm_q;
    wl_d     = words_loaded;
    addr_d   = imem_addr;
    wdata_d  = imem_wdata;
    we_d     = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    if (accept) begin
`ifdef BOOT_CHECKSUM_EN
      csum_d = csum_q ^ in_data;
`endif
      case (state_q)
        HDR_HI: begin
          hdr_hi_d = in_data;
          state_d  = HDR_LO;
        end
        HDR_LO: begin
          len_d = {hdr_hi_q, in_data};
          if (len_d == 16'd0)                       state_d = PAY_END;
          else if (17'(len_d) > 17'(MAX_WORDS))     state_d = ERR;
          else                                      state_d = DATA;
        end
        DATA: begin
          bcnt_d = bcnt_q + 2'd1;
          asm_d  = {asm_q[15:0], in_data};
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = words_loaded[ADDR_W-1:0];
            wdata_d = {asm_q, in_data};
            wl_d    = words_loaded + CNT_W'(1);
            if (16'(wl_d) == len_q) state_d = PAY_END;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        CHK: state_d = (in_data == csum_q) ? DONE : ERR;
`endif
        default: state_d = state_q;
      endcase
    end
    in_ready_d = (state_d != DONE) && (state_d != ERR);
    busy_d     = in_ready_d && (state_d != HDR_HI);
    error_d    = (state_d == ERR);
    run_d      = (state_q == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= HDR_HI;
      hdr_hi_q     <= 8'd0;
      len_q        <= 16'd0;
      bcnt_q       <= 2'd0;
      asm_q        <= 24'd0;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      cpu_run      <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state_q      <= state_d;
      hdr_hi_q     <= hdr_hi_d;
      len_q        <= len_d;
      bcnt_q       <= bcnt_d;
      asm_q        <= asm_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
      in_ready     <= in_ready_d;
      imem_we      <= we_d;
      imem_addr    <= addr_d;
      imem_wdata   <= wdata_d;
      cpu_run      <= run_d;
      busy         <= busy_d;
      error        <= error_d;
      words_loaded <= wl_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: images are decoded by a reference model from the format rules
// and compared against the observed write stream, status outputs and handshake timing.
module tb_imem_boot_loader;
  localparam int unsigned ADDR_W    = 8;
  localparam int          MAX_WORDS = 256;

  typedef logic [7:0] byte_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        in_data = 8'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              busy;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
    .busy(busy), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  byte_t             img[$];
  int                ac[$];
  int                wc[$];
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  int                cyc = 0;
  int                run_cyc = -1;
  bit                overlap = 1'b0;
  int                vectors = 0;
  int                miscompares = 0;

  // Observe at the falling edge, when DUT inputs and outputs are both settled.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (in_valid && in_ready) ac.push_back(cyc);
      if (imem_we) begin
        wa.push_back(imem_addr);
        wd.push_back(imem_wdata);
        wc.push_back(cyc);
      end
      if (cpu_run && run_cyc < 0) run_cyc = cyc;
      if (cpu_run && imem_we) overlap = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    ac.delete(); wc.delete(); wa.delete(); wd.delete();
    run_cyc = -1;
    overlap = 1'b0;
  endtask

  task automatic apply_reset(input string tag, input bit chk_now);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    if (chk_now) begin
      check({tag, " in_ready"},     64'(in_ready),     64'd0);
      check({tag, " imem_we"},      64'(imem_we),      64'd0);
      check({tag, " imem_addr"},    64'(imem_addr),    64'd0);
      check({tag, " imem_wdata"},   64'(imem_wdata),   64'd0);
      check({tag, " cpu_run"},      64'(cpu_run),      64'd0);
      check({tag, " busy"},         64'(busy),         64'd0);
      check({tag, " error"},        64'(error),        64'd0);
      check({tag, " words_loaded"}, 64'(words_loaded), 64'd0);
    end
    step();
    step();
    #2 reset = 1'b1;
    #1;
    if (chk_now) check({tag, " rdy pre-edge"}, 64'(in_ready), 64'd0);
    step();
    if (chk_now) check({tag, " rdy post-edge"}, 64'(in_ready), 64'd1);
    clear_mon();
  endtask

  function automatic void seal();
`ifdef BOOT_CHECKSUM_EN
    byte_t x = 8'h00;
    foreach (img[i]) x ^= img[i];
    img.push_back(x);
`endif
  endfunction

  task automatic build_random(input int n);
    img.delete();
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    repeat (4 * n) img.push_back(8'($urandom));
    seal();
  endtask

  // Present bytes of img (up to limit) with random idle gaps; stop once the loader stops accepting.
  task automatic send(input int gapmax, input int limit, output int nacc);
    int  w;
    bit  stalled;
    nacc    = 0;
    stalled = 1'b0;
    foreach (img[i]) begin
      if (stalled || i >= limit) break;
      if (gapmax > 0) begin
        int g;
        g = int'($urandom_range(gapmax, 0));
        in_valid = 1'b0;
        repeat (g) step();
      end
      in_valid = 1'b1;
      in_data  = img[i];
      w = 0;
      while (!in_ready && w < 12) begin
        step();
        w++;
      end
      if (!in_ready) stalled = 1'b1;
      else begin
        step();
        nacc++;
      end
    end
    in_valid = 1'b0;
  endtask

  // Decode img by the format rules, drive it, then compare writes, status and timing.
  task automatic run_image(input string tag, input int gapmax);
    logic [15:0] n;
    int          need;
    int          exp_acc;
    int          nacc;
    bit          exp_err;
    logic [31:0] ew[$];
    n       = {img[0], img[1]};
    exp_err = 1'b0;
    if (int'(n) > MAX_WORDS) begin
      exp_err = 1'b1;
      exp_acc = 2;
    end else begin
      need = 2 + 4 * int'(n);
`ifdef BOOT_CHECKSUM_EN
      need++;
`endif
      exp_acc = need;
      for (int i = 0; i < int'(n); i++)
        ew.push_back({img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]});
`ifdef BOOT_CHECKSUM_EN
      begin
        byte_t x = 8'h00;
        for (int i = 0; i < need - 1; i++) x ^= img[i];
        if (img[need-1] != x) exp_err = 1'b1;
      end
`endif
    end
    send(gapmax, img.size(), nacc);
    repeat (4) step();
    check({tag, " accepted"}, 64'(nacc), 64'(exp_acc));
    check({tag, " nwrites"}, 64'(wd.size()), 64'(ew.size()));
    for (int i = 0; i < wd.size() && i < ew.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), 64'(wa[i]), 64'(i));
      check($sformatf("%s data[%0d]", tag, i), 64'(wd[i]), 64'(ew[i]));
      if (4 * i + 5 < ac.size())
        check($sformatf("%s wlat[%0d]", tag, i), 64'(wc[i] - ac[4*i+5]), 64'd1);
    end
    check({tag, " words_loaded"}, 64'(words_loaded), 64'(ew.size()));
    check({tag, " cpu_run"}, 64'(cpu_run), 64'(!exp_err));
    check({tag, " error"}, 64'(error), 64'(exp_err));
    check({tag, " in_ready"}, 64'(in_ready), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " run/we overlap"}, 64'(overlap), 64'd0);
    if (!exp_err)
      check({tag, " run latency"}, 64'(run_cyc - (ac.size() > 0 ? ac[$] : -100)), 64'd2);
    else
      check({tag, " run never"}, 64'(run_cyc), 64'(-1));
  endtask

  initial begin
    int nacc;
    #2;
    apply_reset("por", 1'b1);

    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
    seal();
    run_image("n2", 0);
    check("n2 w0 const", 64'(wd.size() > 0 ? wd[0] : 32'h0), 64'h20080005);
    check("n2 w1 const", 64'(wd.size() > 1 ? wd[1] : 32'h0), 64'h8C090000);
    apply_reset("r1", 1'b0);

    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
    seal();
    run_image("n2gap", 5);
    apply_reset("r2", 1'b0);

    img = '{8'h00, 8'h00};
    seal();
    img.push_back(8'h5A);
    img.push_back(8'hA5);
    run_image("n0", 1);
    apply_reset("r3", 1'b0);

    img = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_image("oversize", 0);
    apply_reset("r4", 1'b0);

    build_random(MAX_WORDS);
    run_image("full", 0);
    check("full last addr", 64'(wa.size() > 0 ? wa[$] : '0), 64'hFF);
    apply_reset("r5", 1'b0);

    build_random(3);
    send(0, 6, nacc);
    check("mid accepted", 64'(nacc), 64'd6);
    check("mid we", 64'(imem_we), 64'd1);
    check("mid busy", 64'(busy), 64'd1);
    apply_reset("midrst", 1'b1);
    build_random(3);
    run_image("reload", 2);
    apply_reset("r6", 1'b0);

    for (int k = 0; k < 6; k++) begin
      build_random(int'($urandom_range(24, 1)));
      if (k % 2 == 1) repeat (3) img.push_back(8'($urandom));
      run_image($sformatf("rnd%0d", k), k % 4);
      apply_reset("rr", 1'b0);
    end

`ifdef BOOT_CHECKSUM_EN
    begin
      byte_t x = 8'h00;
      img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
      foreach (img[i]) x ^= img[i];
      img.push_back(x ^ 8'h01);
      run_image("csum_bad", 0);
      apply_reset("r7", 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
